pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5: pipeline stage count, min 4. Stage 0=IF, 1=ID, 2=EX, STAGES-2=MEM, STAGES-1=WB.
REQ-002 SHALL have parameter RW, default 5: register address width.
REQ-003 SHALL have parameter LD_DEPTH, default 4: maximum outstanding loads.
REQ-004 SHALL have parameter MD_LAT, default 4: mul/div latency in cycles, min 1.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port if_busy, input, 1: fetch not complete.
REQ-008 SHALL have ports id_rs_ren, id_rt_ren, id_branch, id_load, input, 1 each: ID read enables, ID instruction is a branch, ID instruction is a load.
REQ-009 SHALL have ports id_rs and id_rt, input, RW each: ID source registers.
REQ-010 SHALL have ports ex_regwen (input, 1) and ex_wreg (input, RW): EX destination.
REQ-011 SHALL have ports data_req and data_addr_ok, input, 1 each: EX data handshake.
REQ-012 SHALL have port md_start, input, 1: mul/div launch pulse in EX.
REQ-013 SHALL have port mem_hold, input, 1: MEM stage cannot advance.
REQ-014 SHALL have ports ld_issue (input, 1) and ld_wreg (input, RW): load accepted by memory, with its destination.
REQ-015 SHALL have port ld_done, input, 1: oldest outstanding load returned.
REQ-016 SHALL have ports exc and eret, input, 1 each: exception or eret committed at WB.
REQ-017 SHALL have ports stall and flush, output, STAGES each: per-stage hold and per-stage bubble/kill.
REQ-018 SHALL have port redirect, output, 1: PC redirect pulse.
REQ-019 SHALL have ports draining, ld_full and sb_err, output, 1 each.

Function
REQ-020 Hold requests:
- h[0] = if_busy
- h[1] = load-use | branch-dep | (id_load & ld_full)
- h[2] = md_busy | (data_req & !data_addr_ok)
- h[STAGES-2] = mem_hold
- all other h bits 0.
REQ-021 stall[j] SHALL equal the OR of h[k] for k>=j (back-pressure propagates to all younger stages).
REQ-022 In IDLE, flush[j] (j>=1) SHALL equal stall[j-1] & !stall[j]; flush[0]=0.
REQ-023 Scoreboard: in-order FIFO of LD_DEPTH register addresses plus a count 0..LD_DEPTH.
- Push: ld_issue with ld_wreg!=0.
- Pop: ld_done, removes the oldest entry.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged, including when full.
REQ-025 Pop when empty SHALL be ignored.
REQ-026 Push when full without a pop SHALL be dropped and SHALL set sb_err sticky until rst.
REQ-027 ld_full SHALL be 1 when count==LD_DEPTH.
REQ-028 load-use SHALL be 1 when an enabled, nonzero id_rs or id_rt matches any valid entry, excluding the entry popped in the same cycle.
REQ-029 branch-dep SHALL be id_branch & ex_regwen & (ex_wreg!=0) & (enabled id_rs or id_rt equals ex_wreg).
REQ-030 md counter:
- md_start with counter 0 loads MD_LAT.
- Counter decrements each cycle while nonzero.
- md_busy = md_start | (counter>1), so EX is held MD_LAT-1 cycles beyond the start cycle.
- md_start while counter nonzero SHALL be ignored.
REQ-031 Flush FSM states: IDLE, DRAIN, REDIR.
REQ-032 In IDLE, exc|eret SHALL force flush=all ones and stall=0 that cycle, and clear the md counter. Next state:
- REDIR if the post-pop count is 0;
- DRAIN otherwise.
REQ-033 In DRAIN:
- stall[0]=1; flush[STAGES-1:1] all ones; draining=1.
- ld_done continues popping; pushes are ignored.
- Exit to REDIR in the cycle after the count reaches 0.
REQ-034 REDIR SHALL assert redirect=1 and flush[0]=1 for exactly one cycle, then return to IDLE.
REQ-035 exc or eret arriving in DRAIN or REDIR SHALL be ignored.
REQ-036 In DRAIN and REDIR, h-derived stalls SHALL be masked except stall[0].

Reset
REQ-037 While rst=1: state=IDLE, scoreboard count=0, md counter=0, sb_err=0; outputs stall=0, flush=all ones, redirect=0, draining=0, ld_full=0.
REQ-038 rst asserted mid-DRAIN or mid-REDIR SHALL return to IDLE on the next edge with no redirect pulse.

Verification
REQ-039 Load-use: ld_issue, ld_wreg=8; next cycle id_rs=8, id_rs_ren=1 -> stall=00011, flush=00100 until the ld_done cycle, then stall=0.
REQ-040 md: md_start at cycle t (MD_LAT=4) -> stall[2:0]=111 for cycles t..t+3, flush[3]=1 for cycles t..t+3, stall=0 at t+4; second md_start at t+1 ignored.
REQ-041 Scoreboard full: 4 ld_issue pulses, then id_load=1 -> ld_full=1, stall[1]=1. ld_issue and ld_done in the same cycle -> count stays 4. 5th push with no pop -> sb_err=1.
REQ-042 exc with 2 loads outstanding -> flush=11111. DRAIN for 2 ld_done pulses, then redirect=1 exactly one cycle, then IDLE. A second exc during DRAIN -> no effect.
REQ-043 Branch dependency: id_branch=1, id_rt=3, id_rt_ren=1, ex_regwen=1, ex_wreg=3 -> stall=00011. With ex_wreg=0 -> no stall.
REQ-044 rst pulse during DRAIN -> next cycle state IDLE, count 0, redirect never asserted.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard controller for an in-order pipeline.
// Stage 0=IF, 1=ID, 2=EX, STAGES-2=MEM, STAGES-1=WB.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   if_busy                  fetch not complete (holds IF)
//   id_rs/rt(_ren)           ID source registers and read enables
//   id_branch, id_load       ID instruction is a branch / a load
//   ex_regwen, ex_wreg       EX destination register
//   data_req, data_addr_ok   EX data-side handshake
//   md_start                 mul/div launch pulse in EX
//   mem_hold                 MEM cannot advance
//   ld_issue, ld_wreg        load accepted by memory, with its destination
//   ld_done                  oldest outstanding load returned
//   exc, eret                exception / eret committed at WB
//   stall, flush             per-stage hold and per-stage bubble/kill
//   redirect                 one-cycle PC redirect pulse
//   draining, ld_full, sb_err  drain in progress, scoreboard full, sticky overflow
//
// Outputs are combinational from state and current inputs, because an
// exception must flush in the same cycle it is committed.
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES   = 5,
  parameter int unsigned RW       = 5,
  parameter int unsigned LD_DEPTH = 4,
  parameter int unsigned MD_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_busy,
  input  logic              id_rs_ren,
  input  logic              id_rt_ren,
  input  logic              id_branch,
  input  logic              id_load,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic              ex_regwen,
  input  logic [RW-1:0]     ex_wreg,
  input  logic              data_req,
  input  logic              data_addr_ok,
  input  logic              md_start,
  input  logic              mem_hold,
  input  logic              ld_issue,
  input  logic [RW-1:0]     ld_wreg,
  input  logic              ld_done,
  input  logic              exc,
  input  logic              eret,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              redirect,
  output logic              draining,
  output logic              ld_full,
  output logic              sb_err
);

  localparam int unsigned CntW = $clog2(LD_DEPTH + 1);
  localparam int unsigned MdW  = $clog2(MD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StDrain, StRedir} state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       sb_q [LD_DEPTH];
  logic [RW-1:0]       sb_d [LD_DEPTH];
  logic [CntW-1:0]     count_q, count_d;
  logic [MdW-1:0]      md_cnt_q, md_cnt_d;
  logic                sb_err_q, sb_err_d;

  logic                exc_ev;
  logic                pop, push_req, push, sb_full;
  logic                match_rs, match_rt, load_use, branch_dep, md_busy;
  logic [STAGES-1:0]   h, stall_raw, flush_idle;

  // Only an IDLE exc/eret starts a flush; later ones are ignored.
  assign exc_ev  = (state_q == StIdle) && (exc || eret);
  assign sb_full = (count_q == CntW'(LD_DEPTH));

  // Scoreboard: shifting FIFO with the oldest entry at index 0.
  // Pushes are only accepted in IDLE outside an exception cycle: once a flush
  // starts, the drain counts down only loads already outstanding.
  always_comb begin
    pop      = ld_done && (count_q != '0);
    push_req = ld_issue && (ld_wreg != '0) && (state_q == StIdle) && !exc_ev;
    push     = push_req && (!sb_full || pop);
    sb_err_d = sb_err_q || (push_req && sb_full && !pop);
    for (int i = 0; i < int'(LD_DEPTH); i++) begin
      if (pop && (i < int'(LD_DEPTH) - 1)) sb_d[i] = sb_q[(i + 1) % int'(LD_DEPTH)];
      else                                  sb_d[i] = sb_q[i];
      if (push && (i == int'(count_q) - (pop ? 1 : 0))) sb_d[i] = ld_wreg;
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Load-use: the entry retiring this cycle no longer blocks.
  always_comb begin
    match_rs = 1'b0;
    match_rt = 1'b0;
    for (int i = 0; i < int'(LD_DEPTH); i++) begin
      if ((i < int'(count_q)) && !(pop && (i == 0))) begin
        if (sb_q[i] == id_rs) match_rs = 1'b1;
        if (sb_q[i] == id_rt) match_rt = 1'b1;
      end
    end
    load_use = (id_rs_ren && (id_rs != '0) && match_rs) ||
               (id_rt_ren && (id_rt != '0) && match_rt);
  end

  assign branch_dep = id_branch && ex_regwen && (ex_wreg != '0) &&
                      ((id_rs_ren && (id_rs == ex_wreg)) || (id_rt_ren && (id_rt == ex_wreg)));

  // Mul/div countdown; a start while busy is dropped.
  assign md_busy = md_start || (md_cnt_q > MdW'(1));

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (exc_ev)                              md_cnt_d = '0;
    else if ((md_cnt_q == '0) && md_start)   md_cnt_d = MdW'(MD_LAT);
    else if (md_cnt_q != '0)                 md_cnt_d = md_cnt_q - MdW'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (exc_ev) state_d = (count_d == '0) ? StRedir : StDrain;
      StDrain: if (count_d == '0) state_d = StRedir;
      StRedir: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Hold requests and their back-pressure onto younger stages.
  always_comb begin
    h              = '0;
    h[0]           = if_busy;
    h[1]           = load_use || branch_dep || (id_load && sb_full);
    h[2]           = md_busy || (data_req && !data_addr_ok);
    h[STAGES-2]    = h[STAGES-2] || mem_hold;
    stall_raw      = '0;
    for (int j = 0; j < int'(STAGES); j++) begin
      for (int k = j; k < int'(STAGES); k++) begin
        if (h[k]) stall_raw[j] = 1'b1;
      end
    end
    flush_idle     = '0;
    for (int j = 1; j < int'(STAGES); j++) begin
      flush_idle[j] = stall_raw[j-1] && !stall_raw[j];
    end
  end

  always_comb begin
    stall    = '0;
    flush    = '0;
    redirect = 1'b0;
    draining = 1'b0;
    ld_full  = 1'b0;
    if (rst) begin
      flush = '1;
    end else begin
      ld_full = sb_full;
      unique case (state_q)
        StIdle: begin
          if (exc_ev) begin
            flush = '1;
          end else begin
            stall = stall_raw;
            flush = flush_idle;
          end
        end
        StDrain: begin
          stall[0] = 1'b1;
          flush    = '1;
          flush[0] = 1'b0;
          draining = 1'b1;
        end
        StRedir: begin
          stall[0] = stall_raw[0];
          flush    = '1;
          redirect = 1'b1;
        end
        default: flush = '1;
      endcase
    end
  end

  assign sb_err = sb_err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      md_cnt_q <= '0;
      sb_err_q <= 1'b0;
      for (int i = 0; i < int'(LD_DEPTH); i++) sb_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      md_cnt_q <= md_cnt_d;
      sb_err_q <= sb_err_d;
      sb_q     <= sb_d;
    end
  end

endmodule
